// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    localparam int WORD_W      = 16;
    localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// Single-port word array: synchronous write, registered read.
module mem_word_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: stalls the pipeline until the
// access completes, then pulses data_valid for one cycle.
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int WORD_ADDR_W = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        stall
);

    localparam int CNT_W = $clog2(MAX_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    mem_state_t             state_d, state_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic                   wr_d, wr_q;
    logic [WORD_ADDR_W-1:0] addr_d, addr_q;
    logic [WORD_W-1:0]      data_d, data_q;
    logic                   data_valid_d, data_valid_q;

    logic        last_cycle;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] unused_addr;

    assign unused_addr = addr;

    assign last_cycle = (state_q == BUSY) && (cnt_q == '0);
    assign mem_we     = last_cycle && wr_q;
    assign mem_re     = last_cycle && !wr_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    wr_d    = wr;
                    addr_d  = addr[WORD_ADDR_W:1];
                    data_d  = data_in;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    data_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    // An arriving request must stall in the very cycle it appears.
    assign stall = !rst &&
                   ((state_q == BUSY) || ((state_q == IDLE) && enable));
    assign data_valid = data_valid_q;

    mem_word_array #(
        .ADDR_W(WORD_ADDR_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (addr_q),
        .wdata(data_q),
        .rdata(data_out)
    );

`ifndef SYNTHESIS
    a_no_stall_and_valid: assert property (
        @(posedge clk) disable iff (rst) !(stall && data_valid));
    a_valid_one_cycle: assert property (
        @(posedge clk) disable iff (rst) data_valid |=> !data_valid);
`endif

endmodule
